// File: rtl/priority_arbiter_tgco_if.sv
// Request/grant bundle of the 4-way priority arbiter. The arbiter is the slave;
// the requester side (or a bench) is the master.
interface priority_arbiter_tgco_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [2:0] Z;
    logic       busy;
    logic       timeout;

    modport master (output req, done, input grant, Z, busy, timeout);
    modport slave  (input req, done, output grant, Z, busy, timeout);
endinterface

// File: rtl/priority_arbiter_tgco.sv
// 4-way fixed-priority arbiter (req[3] highest) with grant holding,
// starvation aging and a forced release after MAX_HOLD busy cycles.
module priority_arbiter_tgco #(
    parameter int AGE_LIMIT = 3,
    parameter int MAX_HOLD  = 8
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    priority_arbiter_tgco_if.slave bus
);
    localparam int AGE_W  = $clog2(AGE_LIMIT + 1);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_GAP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          grant_q, grant_d;
    logic [2:0]          z_q, z_d;
    logic [1:0]          owner_q, owner_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                timeout_q, timeout_d;

    logic                arbitrate;
    logic [3:0]          aged;
    logic [1:0]          win_idx;
    logic                rel_owner;
    logic                hold_expired;

    assign arbitrate = (state_q != ST_BUSY);

    // Ages only move on arbitration edges; winners and idle lines restart at 0.
    for (genvar gi = 0; gi < 4; gi++) begin : g_age
        logic [AGE_W-1:0] age_q, age_d;

        assign aged[gi] = bus.req[gi] && (age_q >= AGE_W'(AGE_LIMIT));

        always_comb begin
            age_d = age_q;
            if (arbitrate) begin
                if (!bus.req[gi] || (win_idx == 2'(gi))) begin
                    age_d = '0;
                end else if (age_q < AGE_W'(AGE_LIMIT)) begin
                    age_d = age_q + AGE_W'(1);
                end
            end
        end

        always_ff @(posedge Clock or negedge Resetn) begin
            if (!Resetn) begin
                age_q <= '0;
            end else begin
                age_q <= age_d;
            end
        end
    end

    // Starved requesters outrank everyone; among a class the highest index wins.
    always_comb begin : win_sel
        logic [3:0] cand;
        cand    = (aged != 4'b0000) ? aged : bus.req;
        win_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (cand[i]) begin
                win_idx = 2'(i);
            end
        end
    end

    assign rel_owner    = bus.done || !bus.req[owner_q];
    assign hold_expired = (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        z_d       = z_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_GAP: begin
                if (bus.req != 4'b0000) begin
                    state_d = ST_BUSY;
                    grant_d = 4'b0001 << win_idx;
                    z_d     = 3'(win_idx) + 3'd1;
                    owner_d = win_idx;
                    hold_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                    grant_d = 4'b0000;
                    z_d     = 3'd0;
                end
            end
            ST_BUSY: begin
                if (rel_owner || hold_expired) begin
                    state_d   = ST_GAP;
                    grant_d   = 4'b0000;
                    z_d       = 3'd0;
                    hold_d    = '0;
                    // A normal release wins over a coincident hold expiry.
                    timeout_d = !rel_owner;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 4'b0000;
                z_d     = 3'd0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= ST_IDLE;
            grant_q   <= 4'b0000;
            z_q       <= 3'd0;
            owner_q   <= 2'd0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            z_q       <= z_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.Z       = z_q;
    assign bus.busy    = (state_q == ST_BUSY);
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_priority_arbiter_tgco.sv
// Bench for priority_arbiter_tgco: per-cycle expectations are queued as stimulus
// is applied and popped when the registered outputs settle after the edge.
module tb_priority_arbiter_tgco;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    priority_arbiter_tgco_if bus ();

    priority_arbiter_tgco #(.AGE_LIMIT(3), .MAX_HOLD(8)) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [8:0] sb[$];

    // Expected {grant, Z, busy, timeout} derived from the grant code.
    function automatic logic [8:0] expect_of(input logic [2:0] z, input logic to);
        logic [3:0] g;
        g = (z == 3'd0) ? 4'b0000 : (4'(1) << (z - 3'd1));
        return {g, z, (z != 3'd0), to};
    endfunction

    // Packed step: {req, done, expected Z, expected timeout}.
    function automatic logic [8:0] st(input logic [3:0] r, input logic d,
                                      input logic [2:0] z, input logic to);
        return {r, d, z, to};
    endfunction

    task automatic apply(input logic [8:0] s);
        bus.req  = s[8:5];
        bus.done = s[4];
        sb.push_back(expect_of(s[3:1], s[0]));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] got, exp;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) rst_n = 1'b1;
            apply(st(4'b0000, 1'b0, 3'd0, 1'b0));
            got = {bus.grant, bus.Z, bus.busy, bus.timeout};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset step %0d: got g/Z/b/t=%b want %b", i, got, exp);
            end
        end
    endtask

    task automatic test_basic();
        logic [8:0] steps[];
        logic [8:0] got, exp;
        steps = '{st(4'b0101, 0, 3'b011, 0), st(4'b0101, 1, 3'b000, 0),
                  st(4'b0001, 0, 3'b001, 0), st(4'b0000, 0, 3'b000, 0),
                  st(4'b0000, 0, 3'b000, 0)};
        foreach (steps[i]) begin
            apply(steps[i]);
            got = {bus.grant, bus.Z, bus.busy, bus.timeout};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL basic step %0d: got g/Z/b/t=%b want %b", i, got, exp);
            end
        end
    endtask

    task automatic test_aging(input string name);
        logic [8:0] steps[];
        logic [8:0] got, exp;
        steps = '{st(4'b1001, 0, 3'b100, 0), st(4'b1001, 1, 3'b000, 0),
                  st(4'b1001, 0, 3'b100, 0), st(4'b1001, 1, 3'b000, 0),
                  st(4'b1001, 0, 3'b100, 0), st(4'b1001, 1, 3'b000, 0),
                  st(4'b1001, 0, 3'b001, 0), st(4'b1001, 1, 3'b000, 0),
                  st(4'b1001, 0, 3'b100, 0), st(4'b0000, 1, 3'b000, 0),
                  st(4'b0000, 0, 3'b000, 0)};
        foreach (steps[i]) begin
            apply(steps[i]);
            got = {bus.grant, bus.Z, bus.busy, bus.timeout};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL %s step %0d: got g/Z/b/t=%b want %b", name, i, got, exp);
            end
        end
    endtask

    task automatic test_timeout();
        logic [8:0] steps[$];
        logic [8:0] got, exp;
        for (int i = 0; i < 8; i++) steps.push_back(st(4'b0010, 0, 3'b010, 0));
        steps.push_back(st(4'b0010, 0, 3'b000, 1));
        // Re-grant, then done lands exactly on the expiry cycle: no timeout.
        for (int i = 0; i < 8; i++) steps.push_back(st(4'b0010, 0, 3'b010, 0));
        steps.push_back(st(4'b0010, 1, 3'b000, 0));
        steps.push_back(st(4'b0000, 0, 3'b000, 0));
        steps.push_back(st(4'b0000, 0, 3'b000, 0));
        foreach (steps[i]) begin
            apply(steps[i]);
            got = {bus.grant, bus.Z, bus.busy, bus.timeout};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL timeout step %0d: got g/Z/b/t=%b want %b", i, got, exp);
            end
        end
    endtask

    task automatic test_no_preempt();
        logic [8:0] steps[];
        logic [8:0] got, exp;
        steps = '{st(4'b0100, 0, 3'b011, 0), st(4'b1100, 0, 3'b011, 0),
                  st(4'b1000, 1, 3'b000, 0), st(4'b1000, 0, 3'b100, 0),
                  st(4'b1000, 1, 3'b000, 0), st(4'b0000, 0, 3'b000, 0)};
        foreach (steps[i]) begin
            apply(steps[i]);
            got = {bus.grant, bus.Z, bus.busy, bus.timeout};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL no_preempt step %0d: got g/Z/b/t=%b want %b", i, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] steps[];
        logic [8:0] got, exp;
        // Build up age on req0, then reset while req3 holds the grant.
        steps = '{st(4'b1001, 0, 3'b100, 0), st(4'b1001, 1, 3'b000, 0),
                  st(4'b1001, 0, 3'b100, 0)};
        foreach (steps[i]) begin
            apply(steps[i]);
            got = {bus.grant, bus.Z, bus.busy, bus.timeout};
            exp = sb.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL async_pre step %0d: got g/Z/b/t=%b want %b", i, got, exp);
            end
        end
        #2 rst_n = 1'b0;
        sb.push_back(expect_of(3'd0, 1'b0));
        #1;
        got = {bus.grant, bus.Z, bus.busy, bus.timeout};
        exp = sb.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL async_drop: got g/Z/b/t=%b want %b", got, exp);
        end
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        test_aging("aging_after_reset");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req  = 4'b0000;
        bus.done = 1'b0;
        test_reset();
        test_basic();
        test_aging("aging");
        test_timeout();
        test_no_preempt();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
